// File: rtl/reg_write_buffer_pkg.sv
// Shared types and constants for the register-file write buffer.
package reg_write_buffer_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/reg_fwd_match.sv
// Youngest-match search over the buffer entries for one bypass lookup port.
module reg_fwd_match
   import reg_write_buffer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DROP_R0 = 1
) (
   input  logic [DEPTH-1:0]                    vld_i,
   input  logic [DEPTH-1:0][ADDR_W-1:0]        addr_i,
   input  logic [DEPTH-1:0][DATA_W-1:0]        data_i,
   input  logic [$clog2(DEPTH)-1:0]            head_i,
   input  logic [ADDR_W-1:0]                   lookup_i,
   output logic                                hit_o,
   output logic [DATA_W-1:0]                   data_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;
   logic             r0_blocked;

   assign r0_blocked = (DROP_R0 != 0) && (lookup_i == ADDR_W'(REG_ZERO));

   // Walk oldest to youngest starting at head; the last match seen is the youngest.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = head_i;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_i + i[PTR_W-1:0];
         if (vld_i[idx] && (addr_i[idx] == lookup_i) && !r0_blocked) begin
            hit_o  = 1'b1;
            data_o = data_i[idx];
         end
      end
   end

endmodule

// File: rtl/reg_write_buffer.sv
// Writeback queue in front of the register file, with youngest-entry bypass for two read ports.
module reg_write_buffer
   import reg_write_buffer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DROP_R0 = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      drain_en,
   output logic                      write,
   output logic [ADDR_W-1:0]         write_addr,
   output logic [DATA_W-1:0]         write_data,
   input  logic [ADDR_W-1:0]         lookup_addr1,
   input  logic [ADDR_W-1:0]         lookup_addr2,
   output logic                      hit1,
   output logic                      hit2,
   output logic [DATA_W-1:0]         fwd_data1,
   output logic [DATA_W-1:0]         fwd_data2,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]             head_q, head_d;
   logic [PTR_W-1:0]             tail_q, tail_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
   logic [DEPTH-1:0][DATA_W-1:0] data_q;

   logic push, enq, drain;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q < FULL);
   assign push     = in_valid && in_ready;
   // A write to r0 completes the handshake but never occupies an entry.
   assign enq      = push && !((DROP_R0 != 0) && (in_addr == ADDR_W'(REG_ZERO)));
   assign drain    = !empty && drain_en;

   assign write      = drain;
   assign write_addr = empty ? '0 : addr_q[head_q];
   assign write_data = empty ? '0 : data_q[head_q];
   assign count      = count_q;

   always_comb begin
      head_d  = head_q + PTR_W'(drain);
      tail_d  = tail_q + PTR_W'(enq);
      count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
      vld_d   = vld_q;
      if (drain) vld_d[head_q] = 1'b0;
      if (enq)   vld_d[tail_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Payload storage needs no reset; entries are qualified by vld_q.
   always_ff @(posedge clk) begin
      if (rst_n && enq) begin
         addr_q[tail_q] <= in_addr;
         data_q[tail_q] <= in_data;
      end
   end

   reg_fwd_match #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_R0(DROP_R0)
   ) u_match1 (
      .vld_i(vld_q), .addr_i(addr_q), .data_i(data_q), .head_i(head_q),
      .lookup_i(lookup_addr1), .hit_o(hit1), .data_o(fwd_data1)
   );

   reg_fwd_match #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_R0(DROP_R0)
   ) u_match2 (
      .vld_i(vld_q), .addr_i(addr_q), .data_i(data_q), .head_i(head_q),
      .lookup_i(lookup_addr2), .hit_o(hit2), .data_o(fwd_data2)
   );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Scoreboard bench for reg_write_buffer: queue-based reference model plus directed and random stimulus.
module tb_reg_write_buffer;
   import reg_write_buffer_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        drain_en;
   logic        write;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [4:0]  lookup_addr1, lookup_addr2;
   logic        hit1, hit2;
   logic [31:0] fwd_data1, fwd_data2;
   logic [2:0]  count;
   logic        empty;

   int          n_chk;
   int          n_fail;
   bit          chk_en;
   int          n_rfw;
   wr_req_t     mq[$];
   wr_req_t     drained[$];
   logic [31:0] rf[32];

   logic [4:0]  exp_a[5] = '{5'd5, 5'd5, 5'd7, 5'd9, 5'd10};
   logic [31:0] exp_d[5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

   always #5 clk = ~clk;

   reg_write_buffer #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32), .DROP_R0(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .drain_en(drain_en), .write(write), .write_addr(write_addr), .write_data(write_data),
      .lookup_addr1(lookup_addr1), .lookup_addr2(lookup_addr2),
      .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count), .empty(empty)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference bypass: youngest queued entry with a matching address; r0 never hits.
   function automatic void model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (a == REG_ZERO) return;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].addr == a) begin
            h = 1'b1;
            d = mq[i].data;
         end
      end
   endfunction

   // Monitor: compare outputs mid-cycle, then apply the coming edge to the model.
   always @(negedge clk) begin : mon
      logic        eh;
      logic [31:0] ed;
      bit          dr, pu;
      if (chk_en) begin
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         chk("in_ready", in_ready, mq.size() < DEPTH);
         chk("write", write, (mq.size() != 0) && drain_en);
         if (write && mq.size() != 0) begin
            chk("write_addr", write_addr, mq[0].addr);
            chk("write_data", write_data, mq[0].data);
         end
         if (write && rst_n) begin
            drained.push_back('{write_addr, write_data});
            rf[write_addr] = write_data;
            n_rfw++;
         end
         model_lookup(lookup_addr1, eh, ed);
         chk("hit1", hit1, eh);
         chk("fwd_data1", fwd_data1, ed);
         model_lookup(lookup_addr2, eh, ed);
         chk("hit2", hit2, eh);
         chk("fwd_data2", fwd_data2, ed);
         if (!rst_n) begin
            mq.delete();
         end else begin
            dr = (mq.size() != 0) && drain_en;
            pu = in_valid && (mq.size() < DEPTH);
            if (dr) void'(mq.pop_front());
            if (pu && in_addr != REG_ZERO) mq.push_back('{in_addr, in_data});
         end
      end else begin
         mq.delete();
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
      #1;
   endtask

   task automatic push1(input logic [4:0] a, input logic [31:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      cyc();
   endtask

   initial begin
      int w0;
      n_chk = 0; n_fail = 0; chk_en = 0; n_rfw = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; drain_en = 1'b0;
      lookup_addr1 = '0; lookup_addr2 = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;

      // reset then idle
      repeat (2) cyc();
      rst_n = 1'b1; chk_en = 1;
      probe();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_write", write, 0);
      chk("rst_write_addr", write_addr, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_hit", {hit1, hit2}, 0);
      chk("rst_fwd", {fwd_data1, fwd_data2}, 0);

      // single push drains next cycle
      cyc();
      drain_en = 1'b1;
      push1(5'd3, 32'hAAAA_0001);
      in_valid = 1'b0;
      probe();
      chk("t2_write", write, 1);
      chk("t2_addr", write_addr, 3);
      chk("t2_data", write_data, 32'hAAAA_0001);
      cyc();
      probe();
      chk("t2_empty", empty, 1);
      chk("t2_rf3", rf[3], 32'hAAAA_0001);

      // fill with drain held, fifth push refused
      cyc();
      drain_en = 1'b0;
      push1(5'd5, 32'h11);
      push1(5'd5, 32'h22);
      push1(5'd7, 32'h33);
      push1(5'd9, 32'h44);
      push1(5'd11, 32'h66);
      in_valid = 1'b0;
      lookup_addr1 = 5'd5;
      lookup_addr2 = 5'd8;
      probe();
      chk("t3_count", count, 4);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_hit1", hit1, 1);
      chk("t3_fwd1", fwd_data1, 32'h22);
      chk("t3_hit2", hit2, 0);

      // drain from full while a push waits; order crosses pointer wrap
      cyc();
      drained.delete();
      drain_en = 1'b1;
      in_valid = 1'b1; in_addr = 5'd10; in_data = 32'h55;
      cyc();
      cyc();
      in_valid = 1'b0;
      repeat (5) cyc();
      probe();
      chk("t4_ndrained", drained.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < drained.size()) begin
            chk("t4_order_addr", drained[k].addr, exp_a[k]);
            chk("t4_order_data", drained[k].data, exp_d[k]);
         end
      end
      chk("t4_count", count, 0);

      // r0 request handshakes but is dropped
      cyc();
      lookup_addr1 = 5'd0;
      in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hDEAD;
      probe();
      chk("t5_in_ready", in_ready, 1);
      chk("t5_hit1", hit1, 0);
      cyc();
      in_valid = 1'b0;
      probe();
      chk("t5_count", count, 0);
      chk("t5_write", write, 0);
      cyc();
      probe();
      chk("t5_write2", write, 0);
      chk("t5_empty", empty, 1);

      // reset mid-drain discards pending writes
      cyc();
      drain_en = 1'b0;
      push1(5'd1, 32'h101);
      push1(5'd2, 32'h202);
      push1(5'd4, 32'h404);
      in_valid = 1'b0;
      drain_en = 1'b1;
      rst_n = 1'b0;
      probe();
      chk("t6_write_in_rst", write, 1);
      cyc();
      rst_n = 1'b1;
      w0 = n_rfw;
      probe();
      chk("t6_count", count, 0);
      chk("t6_write", write, 0);
      repeat (4) cyc();
      probe();
      chk("t6_no_rf_writes", n_rfw, w0);

      // randomized traffic
      cyc();
      for (int n = 0; n < 2000; n++) begin
         in_valid     = 1'($urandom_range(0, 1));
         in_addr      = 5'($urandom_range(0, 7));
         in_data      = $urandom;
         drain_en     = ($urandom_range(0, 9) < 7);
         lookup_addr1 = 5'($urandom_range(0, 7));
         lookup_addr2 = 5'($urandom_range(0, 7));
         rst_n        = ($urandom_range(0, 299) != 0);
         cyc();
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_write_buffer.md
Name: reg_write_buffer

Overview:
- Initiator side of the register-file write port: queues writeback requests from the execute/memory stages and drains them into the 32x32 register file, at most one write per cycle.
- Offers a bypass lookup for the two read addresses, so decode sees pending (not yet written) values.
- Sits between the writeback stage and the register file's write_addr/write_data/write inputs.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- DROP_R0, 1, when 1 a request to address 0 is accepted but never enqueued

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  writeback request present
- in_ready  output  1  buffer can accept a request this cycle
- in_addr  input  ADDR_W  destination register
- in_data  input  DATA_W  value to write
- drain_en  input  1  permits a drain write this cycle (0 = hold the head)
- write  output  1  register-file write enable
- write_addr  output  ADDR_W  register-file write address
- write_data  output  DATA_W  register-file write data
- lookup_addr1  input  ADDR_W  read-port-1 address to check
- lookup_addr2  input  ADDR_W  read-port-2 address to check
- hit1  output  1  a pending entry matches lookup_addr1
- hit2  output  1  a pending entry matches lookup_addr2
- fwd_data1  output  DATA_W  data of the youngest matching entry for addr1
- fwd_data2  output  DATA_W  data of the youngest matching entry for addr2
- count  output  clog2(DEPTH)+1  occupied entries
- empty  output  1  count == 0

Behaviour:
- Reset (rst_n==0 at posedge): head, tail and count cleared; all entry valid bits cleared. Any pending writes are discarded, including mid-drain ones.
- Outputs after reset: write=0, count=0, empty=1, in_ready=1, hit1=hit2=0. write_addr, write_data, fwd_data1 and fwd_data2 are 0.
- in_ready = (count < DEPTH). It is combinational from count and does not depend on drain_en.
- Push: on a posedge with in_valid && in_ready, the entry {in_addr, in_data} is written at tail. tail increments modulo DEPTH.
- With DROP_R0=1 and in_addr==0, the request is handshaken but no entry is written and tail is unchanged.
- Drain: write = !empty && drain_en. write_addr and write_data come from the head entry combinationally.
- On a posedge with write==1, the head entry is invalidated and head increments modulo DEPTH. The register file captures the write on the same edge.
- Drain latency: a request pushed into an empty buffer at edge N appears on write during cycle N+1 and is committed at edge N+1 (if drain_en is high).
- Simultaneous push and drain on the same edge: count is unchanged. Allowed at any count < DEPTH.
- At count == DEPTH, push is blocked even if a drain occurs that edge.
- count updates each edge by +push-drain and never exceeds DEPTH or underflows.
- Bypass is combinational over stored valid entries only. An in-flight input on in_* is not forwarded.
- Among multiple matching entries, the youngest one (nearest tail) wins.
- The head entry being drained this cycle still counts as a hit. After the edge, the register file holds that value.
- With DROP_R0=1, a lookup of address 0 never hits.
- When there is no hit, fwd_dataN is 0.
- Pointer wrap: head and tail wrap independently; full vs empty is distinguished by count only.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, a REG_ZERO address constant, and the write-request struct {addr, data}.
- Natural sub-module: reg_fwd_match, the combinational youngest-match search over the DEPTH entries. One instance per lookup port.

Test Plan:
- Reset then idle -> write=0, empty=1, count=0, in_ready=1, hit1=hit2=0.
- Push {3,0xAAAA_0001} with drain_en=1 -> next cycle write=1, write_addr=3, write_data=0xAAAA_0001. Following cycle empty=1 and the register-file read of r3 returns 0xAAAA_0001.
- drain_en=0; push {5,0x11}, {5,0x22}, {7,0x33}, {9,0x44} -> count=4, in_ready=0, a fifth push is not accepted. lookup_addr1=5 gives hit1=1, fwd_data1=0x22; lookup_addr2=8 gives hit2=0.
- From the full state, set drain_en=1 and hold in_valid with {10,0x55} -> one entry drains first, then the push is accepted. Drain order is 5/0x11, 5/0x22, 7/0x33, 9/0x44, 10/0x55, with wrap-around of head and tail verified.
- DROP_R0=1, push {0,0xDEAD} -> handshake completes, count stays 0, write never asserts, lookup_addr1=0 gives hit1=0.
- Push three entries, then drive rst_n=0 for one cycle while write=1 -> next cycle count=0, write=0, and no further register-file writes occur.
